// File: rtl/nexusv_apb_master_pkg.sv
// Shared definitions for the nexusV APB4 master bridge: FSM state encoding,
// RV32 load/store funct3 codes, the APB window decode bit and request checks.
package nexusv_apb_master_pkg;

    // Peripherals live in the upper address half.
    localparam int unsigned ApbBaseBit = 31;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StErr    = 2'd3
    } state_t;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write) begin
            return (f3 == F3Sb) || (f3 == F3Sh) || (f3 == F3Sw);
        end
        return (f3 == F3Lb) || (f3 == F3Lh) || (f3 == F3Lw) || (f3 == F3Lbu) || (f3 == F3Lhu);
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) || ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/nexusv_apb_master_if.sv
// Bundle of core request/response and APB4 bus signals for the nexusV bridge.
// The master modport is the bridge's view; slave is the core plus peripherals.
interface nexusv_apb_master_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_SLV = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_W-1:0]      req_addr;
    logic [31:0]            req_wdata;
    logic [2:0]             req_funct3;
    logic                   rsp_valid;
    logic [31:0]            rsp_rdata;
    logic                   rsp_err;
    logic [ADDR_W-1:0]      paddr;
    logic                   pwrite;
    logic [NUM_SLV-1:0]     psel;
    logic                   penable;
    logic [31:0]            pwdata;
    logic [3:0]             pstrb;
    logic [NUM_SLV*32-1:0]  prdata;
    logic [NUM_SLV-1:0]     pready;
    logic [NUM_SLV-1:0]     pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/nexusv_apb_master_lane_align.sv
// Byte-lane steering: store strobes and replicated write data, plus RV32
// load extraction and sign/zero extension, all from funct3 and addr[1:0].
module nexusv_apb_master_lane_align
    import nexusv_apb_master_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate the right-aligned datum and enable its lanes.
    always_comb begin
        pwdata = wdata;
        pstrb  = 4'b0000;
        if (write) begin
            case (funct3[1:0])
                2'b00: begin
                    pwdata = {4{wdata[7:0]}};
                    pstrb  = 4'b0001 << addr_lo;
                end
                2'b01: begin
                    pwdata = {2{wdata[15:0]}};
                    pstrb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    pwdata = wdata;
                    pstrb  = 4'b1111;
                end
            endcase
        end
    end

    // Load side: pick the addressed lane, then extend per funct3.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = rdata_raw[7:0];
            2'b01:   byte_sel = rdata_raw[15:8];
            2'b10:   byte_sel = rdata_raw[23:16];
            default: byte_sel = rdata_raw[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
        case (funct3)
            F3Lb:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3Lh:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3Lbu:   rdata_ext = {24'h0, byte_sel};
            F3Lhu:   rdata_ext = {16'h0, half_sel};
            default: rdata_ext = rdata_raw;
        endcase
    end

endmodule

// File: rtl/nexusv_apb_master.sv
// nexusV APB4 master bridge: accepts core load/store requests, runs the
// SETUP/ACCESS handshake on one of NUM_SLV slaves and returns a one-cycle
// response. Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC waits.
module nexusv_apb_master
    import nexusv_apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned SLV_SEL_LSB = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    nexusv_apb_master_if.master bus
);

    localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [31:0]         wdata_q;
    logic [2:0]          funct3_q;
    logic [IdxW-1:0]     idx_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

    logic [IdxW-1:0]     req_idx;
    logic                req_bad;
    logic                accept;
    logic                timeout;
    logic [NUM_SLV-1:0]  sel_onehot;
    logic [31:0]         sel_prdata;
    logic                sel_pready;
    logic                sel_pslverr;
    logic [31:0]         lane_pwdata;
    logic [3:0]          lane_pstrb;
    logic [31:0]         rdata_ext;

    if (NUM_SLV > 1) begin : g_idx
        assign req_idx = bus.req_addr[SLV_SEL_LSB +: IdxW];
    end else begin : g_idx_single
        assign req_idx = '0;
    end

    assign accept  = (state_q == StIdle) && bus.req_valid;
    // Index range check only bites for non-power-of-two NUM_SLV.
    assign req_bad = !f3_legal(bus.req_write, bus.req_funct3)
                   || misaligned(bus.req_funct3, bus.req_addr[1:0])
                   || (32'(req_idx) >= NUM_SLV);

    // Decode the captured index and mux the selected slave's response.
    always_comb begin
        sel_onehot  = '0;
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (32'(idx_q) == i) begin
                sel_onehot[i] = 1'b1;
                sel_prdata    = bus.prdata[32*i +: 32];
                sel_pready    = bus.pready[i];
                sel_pslverr   = bus.pslverr[i];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    logic [CntW-1:0] wait_cnt_q;

    // Count consecutive not-ready ACCESS cycles; cleared outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != StAccess) begin
            wait_cnt_q <= '0;
        end else if (!sel_pready) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StAccess) && !sel_pready
                   && (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));
`else
    // Timeout logic compiled out; keep the parameter referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_valid) state_d = req_bad ? StErr : StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (sel_pready || timeout) state_d = StIdle;
            StErr:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // APB control and request handshake outputs.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.psel      = '0;
        bus.penable   = 1'b0;
        unique case (state_q)
            StIdle:   bus.req_ready = 1'b1;
            StSetup:  bus.psel = sel_onehot;
            StAccess: begin
                bus.psel    = sel_onehot;
                bus.penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture the request on accept; these drive the APB address/data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            funct3_q <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            write_q  <= bus.req_write;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
            idx_q    <= req_idx;
        end
    end

    // Response next-state: data and error hold between responses.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (state_q == StErr) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end else if (state_q == StAccess && sel_pready) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = sel_pslverr;
            rsp_rdata_d = (sel_pslverr || write_q) ? 32'h0 : rdata_ext;
        end else if (timeout) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    nexusv_apb_master_lane_align u_lane_align (
        .write     (write_q),
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata_raw (sel_prdata),
        .pwdata    (lane_pwdata),
        .pstrb     (lane_pstrb),
        .rdata_ext (rdata_ext)
    );

    assign bus.paddr     = addr_q;
    assign bus.pwrite    = write_q;
    assign bus.pwdata    = lane_pwdata;
    assign bus.pstrb     = lane_pstrb;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_nexusv_apb_master.sv
// Self-checking bench for nexusv_apb_master: directed scenarios plus a
// randomized run against a behavioural model of RV32 lane/extension rules.
module tb_nexusv_apb_master;

    localparam int NumSlv = 4;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    nexusv_apb_master_if #(.ADDR_W(32), .NUM_SLV(NumSlv)) bus ();

    nexusv_apb_master #(
        .ADDR_W      (32),
        .NUM_SLV     (NumSlv),
        .SLV_SEL_LSB (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready_at_accept;
        logic        valid_at_accept;
        logic        any_psel;
        logic        saw_setup;
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        stable;
        int          latency;
        int          access_cycles;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    typedef struct {
        logic        err_path;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    // Reference: access size from funct3, lanes by byte offset, plain shifts.
    function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] f3,
                                   input logic [31:0] raw, input logic serr);
        exp_t e;
        int size;
        int off;
        logic legal;
        logic [31:0] v;
        logic [31:0] mask;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        legal = wr ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        e.err_path = !legal || ((off % size) != 0);
        e.pwdata = '0;
        e.pstrb  = '0;
        e.rdata  = '0;
        e.err    = e.err_path || serr;
        if (!e.err_path) begin
            if (wr) begin
                for (int l = 0; l < 4; l++) e.pwdata[8*l +: 8] = wdata[8*(l % size) +: 8];
                e.pstrb = 4'(((1 << size) - 1) << off);
            end else if (!serr) begin
                v = raw >> (8 * off);
                if (size < 4) begin
                    mask = (32'h1 << (8 * size)) - 1;
                    v = v & mask;
                    if (!f3[2] && v[8*size-1]) v = v | ~mask;
                end
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Drive one request and play the selected slave; returns what was observed.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int waits, input logic serr,
                           input logic [31:0] raw, output obs_t o);
        int idx;
        int acc;
        idx = int'(addr[17:16]);
        o.ready_at_accept = 1'b0;
        o.valid_at_accept = 1'b0;
        o.any_psel  = 1'b0;
        o.saw_setup = 1'b0;
        o.psel   = '0;
        o.paddr  = '0;
        o.pwrite = 1'b0;
        o.pwdata = '0;
        o.pstrb  = '0;
        o.stable = 1'b1;
        o.latency = -1;
        o.access_cycles = 0;
        o.rdata = '0;
        o.err   = 1'b0;
        for (int i = 0; i < NumSlv; i++) bus.prdata[32*i +: 32] = (i == idx) ? raw : $urandom;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        bus.pready  = 4'($urandom);
        bus.pslverr = 4'($urandom);
        bus.pready[idx]  = 1'b0;
        bus.pslverr[idx] = serr;
        o.ready_at_accept = bus.req_ready;
        o.valid_at_accept = bus.rsp_valid;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        acc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.rsp_valid) begin
                o.latency = cyc;
                o.rdata   = bus.rsp_rdata;
                o.err     = bus.rsp_err;
                break;
            end
            bus.pready  = 4'($urandom);
            bus.pslverr = 4'($urandom);
            bus.pready[idx]  = 1'b0;
            bus.pslverr[idx] = serr;
            if (bus.psel != '0) o.any_psel = 1'b1;
            if (bus.psel != '0 && !bus.penable) begin
                o.saw_setup = 1'b1;
                o.psel   = bus.psel;
                o.paddr  = bus.paddr;
                o.pwrite = bus.pwrite;
                o.pwdata = bus.pwdata;
                o.pstrb  = bus.pstrb;
            end
            if (bus.penable) begin
                if (bus.psel !== o.psel || bus.paddr !== o.paddr || bus.pwrite !== o.pwrite ||
                    bus.pwdata !== o.pwdata || bus.pstrb !== o.pstrb) o.stable = 1'b0;
                if (acc == waits) bus.pready[idx] = 1'b1;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        o.access_cycles = acc;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (bus.psel !== 4'b0 || bus.penable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_psel_penable: psel=%b penable=%b, want 0/0", bus.psel, bus.penable);
        end
        n_tests++;
        if (bus.paddr !== 32'h0 || bus.pwrite !== 1'b0 || bus.pwdata !== 32'h0 || bus.pstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_bus: paddr=%h pwrite=%b pwdata=%h pstrb=%h, want all 0",
                     bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb);
        end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b, want 0/0/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_word();
        obs_t o;
        run_txn(1'b1, 32'h8001_0004, 32'hDEAD_BEEF, 3'b010, 0, 1'b0, 32'h0, o);
        n_tests++;
        if (o.psel !== 4'b0010 || o.pstrb !== 4'hF || o.pwdata !== 32'hDEAD_BEEF || o.pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_setup: psel=%b pstrb=%h pwdata=%h pwrite=%b, want 0010/f/deadbeef/1",
                     o.psel, o.pstrb, o.pwdata, o.pwrite);
        end
        n_tests++;
        if (o.latency !== 3 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_rsp: latency=%0d err=%b rdata=%h, want 3/0/0", o.latency, o.err, o.rdata);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_pulse_width: rsp_valid=%b one cycle later, want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_load_byte();
        obs_t o;
        run_txn(1'b0, 32'h8000_0003, 32'h0, 3'b000, 0, 1'b0, 32'h80FF_FFFF, o);
        n_tests++;
        if (o.pstrb !== 4'h0 || o.rdata !== 32'hFFFF_FF80 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb: pstrb=%h rdata=%h err=%b, want 0/ffffff80/0", o.pstrb, o.rdata, o.err);
        end
        run_txn(1'b0, 32'h8000_0003, 32'h0, 3'b100, 0, 1'b0, 32'h80FF_FFFF, o);
        n_tests++;
        if (o.rdata !== 32'h0000_0080 || o.psel !== 4'b0001) begin
            n_fail++;
            $display("FAIL lbu: rdata=%h psel=%b, want 00000080/0001", o.rdata, o.psel);
        end
    endtask

    task automatic test_store_half_wait();
        obs_t o;
        run_txn(1'b1, 32'h8002_0002, 32'h0000_1234, 3'b001, 2, 1'b0, 32'h0, o);
        n_tests++;
        if (o.pwdata !== 32'h1234_1234 || o.pstrb !== 4'b1100 || o.psel !== 4'b0100) begin
            n_fail++;
            $display("FAIL sh_setup: pwdata=%h pstrb=%b psel=%b, want 12341234/1100/0100",
                     o.pwdata, o.pstrb, o.psel);
        end
        n_tests++;
        if (o.stable !== 1'b1 || o.latency !== 5 || o.access_cycles !== 3) begin
            n_fail++;
            $display("FAIL sh_wait: stable=%b latency=%0d access=%0d, want 1/5/3",
                     o.stable, o.latency, o.access_cycles);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(1'b0, 32'h8000_0001, 32'h0, 3'b001, 0, 1'b0, 32'h1234_5678, o);
        n_tests++;
        if (o.any_psel !== 1'b0 || o.latency !== 2 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL lh_misaligned: psel_seen=%b latency=%0d err=%b rdata=%h, want 0/2/1/0",
                     o.any_psel, o.latency, o.err, o.rdata);
        end
        run_txn(1'b1, 32'h8003_0000, 32'h5555_AAAA, 3'b011, 0, 1'b0, 32'h0, o);
        n_tests++;
        if (o.any_psel !== 1'b0 || o.latency !== 2 || o.err !== 1'b1) begin
            n_fail++;
            $display("FAIL store_bad_f3: psel_seen=%b latency=%0d err=%b, want 0/2/1",
                     o.any_psel, o.latency, o.err);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        run_txn(1'b0, 32'h8003_0008, 32'h0, 3'b010, 1, 1'b1, 32'hCAFE_F00D, o);
        n_tests++;
        if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.latency !== 4) begin
            n_fail++;
            $display("FAIL lw_slverr: err=%b rdata=%h latency=%0d, want 1/0/4", o.err, o.rdata, o.latency);
        end
        run_txn(1'b0, 32'h8003_0000, 32'h0, 3'b010, 0, 1'b0, 32'h1122_3344, o);
        n_tests++;
        if (o.valid_at_accept !== 1'b1 || o.ready_at_accept !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: rsp_valid=%b req_ready=%b at accept, want 1/1",
                     o.valid_at_accept, o.ready_at_accept);
        end
        n_tests++;
        if (o.latency !== 3 || o.err !== 1'b0 || o.rdata !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL b2b_rsp: latency=%0d err=%b rdata=%h, want 3/0/11223344",
                     o.latency, o.err, o.rdata);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] raw;
        logic [2:0] f3;
        logic serr;
        int waits;
        int exp_lat;
        for (int n = 0; n < 60; n++) begin
            wr    = 1'($urandom);
            addr  = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
            wdata = $urandom;
            raw   = $urandom;
            f3    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (wr ? 3'($urandom_range(0, 2))
                    : 3'($urandom_range(0, 5)));
            serr  = ($urandom_range(0, 4) == 0);
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            e = model(wr, addr, wdata, f3, raw, serr);
            run_txn(wr, addr, wdata, f3, waits, serr, raw, o);
            exp_lat = e.err_path ? 2 : 3 + waits;
            n_tests++;
            if (o.latency !== exp_lat || o.err !== e.err || o.rdata !== e.rdata) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d] wr=%b addr=%h f3=%0d: latency=%0d err=%b rdata=%h, want %0d/%b/%h",
                         n, wr, addr, f3, o.latency, o.err, o.rdata, exp_lat, e.err, e.rdata);
            end
            n_tests++;
            if (o.any_psel !== !e.err_path) begin
                n_fail++;
                $display("FAIL rand_psel_seen[%0d]: got %b want %b", n, o.any_psel, !e.err_path);
            end
            if (!e.err_path) begin
                n_tests++;
                if (o.psel !== (4'b0001 << addr[17:16]) || o.paddr !== addr || o.pwrite !== wr ||
                    o.pstrb !== e.pstrb || o.stable !== 1'b1 || (wr && o.pwdata !== e.pwdata)) begin
                    n_fail++;
                    $display("FAIL rand_bus[%0d] wr=%b addr=%h f3=%0d: psel=%b paddr=%h pstrb=%b pwdata=%h stable=%b, want pstrb=%b pwdata=%h",
                             n, wr, addr, f3, o.psel, o.paddr, o.pstrb, o.pwdata, o.stable,
                             e.pstrb, e.pwdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        logic got_valid;
        bus.prdata  = '0;
        bus.pready  = '0;
        bus.pslverr = '0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h8001_0000;
        bus.req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.penable !== 1'b1 || bus.psel !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_reset_in_access: penable=%b psel=%b, want 1/0010", bus.penable, bus.psel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.psel !== 4'b0 || bus.penable !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async_drop: psel=%b penable=%b, want 0/0", bus.psel, bus.penable);
        end
        got_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) got_valid = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) got_valid = 1'b1;
        end
        n_tests++;
        if (got_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_no_rsp: rsp_valid_seen=%b req_ready=%b, want 0/1",
                     got_valid, bus.req_ready);
        end
        run_txn(1'b0, 32'h8002_0000, 32'h0, 3'b101, 0, 1'b0, 32'h9ABC_8001, o);
        n_tests++;
        if (o.latency !== 3 || o.rdata !== 32'h0000_8001 || o.err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_recover: latency=%0d rdata=%h err=%b, want 3/00008001/0",
                     o.latency, o.rdata, o.err);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_txn(1'b0, 32'h8001_0000, 32'h0, 3'b010, 1000, 1'b0, 32'h7777_7777, o);
        n_tests++;
        if (o.access_cycles !== 8 || o.latency !== 10 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout: access=%0d latency=%0d err=%b rdata=%h, want 8/10/1/0",
                     o.access_cycles, o.latency, o.err, o.rdata);
        end
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        bus.prdata     = '0;
        bus.pready     = '0;
        bus.pslverr    = '0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_store_half_wait();
        test_misaligned();
        test_back_to_back();
        test_random();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/nexusv_apb_master.md
# nexusV_apb_master

Parametrised APB4 master bridge between the nexusV multicycle core's load/store path and up to `NUM_SLV` peripheral slaves in the upper address half (`addr[31]=1`). It replaces the core's tied-off `apb_ready`/`apb_read_data` stubs with a real SETUP/ACCESS state machine. Features:
- per-slave `psel` decode;
- wait-state support via `pready`;
- `pslverr` reporting;
- byte-lane strobes and RV32 load extension derived from `funct3`.

## Interface
Parameters:
- `ADDR_W`, 32: request and `paddr` width.
- `NUM_SLV`, 4: number of APB slaves, power of two, 1..16.
- `SLV_SEL_LSB`, 16: lowest address bit of the slave-index field `addr[SLV_SEL_LSB +: clog2(NUM_SLV)]`.
- `TIMEOUT_CYC`, 255: maximum ACCESS wait cycles. Used only with `APB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: bridge is idle and accepts a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_funct3` in 3: RV32 load/store `funct3`.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `rsp_err` out 1: slave error, misalignment, bad slave index, or timeout. Valid with `rsp_valid`.
- `paddr` out ADDR_W; `pwrite` out 1; `psel` out NUM_SLV (one-hot); `penable` out 1.
- `pwdata` out 32; `pstrb` out 4.
- `prdata` in NUM_SLV*32: flattened read data. Slave *i* occupies bits `[32i+31:32i]`.
- `pready` in NUM_SLV; `pslverr` in NUM_SLV.

## Operation
- **States:** IDLE, SETUP, ACCESS, ERR.
- **IDLE:**
  - `req_ready=1`.
  - When `req_valid`, the request is captured into registers.
  - Next state is ERR if:
    - the access is misaligned (halfword with `addr[0]=1`, word with `addr[1:0]≠0`);
    - the slave index is ≥ NUM_SLV (only possible when NUM_SLV is not a power of two, so treated as a defensive check); or
    - `funct3` is illegal (loads: 3, 6, 7; stores: ≥3).
  - Otherwise next state is SETUP.
- **SETUP:**
  - `psel[idx]=1`, `penable=0`.
  - `paddr`, `pwrite`, `pwdata` and `pstrb` are driven from registers and stay stable through ACCESS.
  - Next state is always ACCESS.
- **ACCESS:**
  - `penable=1`.
  - The bridge samples `pready[idx]`.
  - On 1: capture `prdata`/`pslverr` of slave `idx`, drop `psel`/`penable`, pulse `rsp_valid` next cycle, return to IDLE.
- **ERR:** drives no APB activity, pulses `rsp_valid` with `rsp_err=1` next cycle, returns to IDLE.
- **Stores:**
  - SB: `pwdata = {4{wdata[7:0]}}`, `pstrb = 1<<addr[1:0]`.
  - SH: `pwdata = {2{wdata[15:0]}}`, `pstrb = addr[1] ? 4'b1100 : 4'b0011`.
  - SW: `pwdata = wdata`, `pstrb = 4'b1111`.
- **Loads:**
  - `pstrb=0`.
  - `rsp_rdata` is the lane selected by `addr[1:0]`, sign-extended for LB/LH and zero-extended for LBU/LHU. LW passes through.
- **On `pslverr=1`:** `rsp_err=1` and `rsp_rdata=0`.

## Timing
- **Reset values:**
  - `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`, `pstrb=0`.
  - `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - State is IDLE, so `req_ready=1`.
- **Latency:**
  - Request accepted at edge E. SETUP occupies cycle E+1, ACCESS occupies E+2.
  - With zero wait states, `rsp_valid` is high in cycle E+3. Each low `pready` cycle adds one cycle.
  - The error path gives `rsp_valid` in cycle E+2.
- **Back-to-back:** `req_ready=1` in the same cycle as `rsp_valid`, so a new request is accepted there. The minimum spacing between accepts is 3 cycles.
- `rsp_valid` is a registered one-cycle pulse. `rsp_rdata` and `rsp_err` hold until the next response.
- **Reset asserted mid-transfer:** `psel`/`penable` drop immediately (asynchronously) and no `rsp_valid` is produced.
- `pready` and `pslverr` of non-selected slaves are ignored.

## Configuration
- **`APB_TIMEOUT_EN` defined:**
  - A wait counter clears on entry to ACCESS.
  - If `pready[idx]` stays low for `TIMEOUT_CYC` consecutive ACCESS cycles, the transfer aborts: `psel`/`penable` drop, then `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`, and the state returns to IDLE.
- **Undefined:** no counter exists and ACCESS waits indefinitely.

## Structure
- `rv_defs.vh` holds:
  - state encodings;
  - `funct3` constants (LB/LH/LW/LBU/LHU/SB/SH/SW);
  - the `APB_BASE` decode bit (31).
- One combinational sub-module, `apb_lane_align`, generates `pstrb`, replicated `pwdata` and the extended read data from `funct3` and `addr[1:0]`.
- The FSM, request registers and `prdata` mux live in the top block.

## Test plan
- SW to 0x8001_0004 (idx 1), data 0xDEADBEEF, `pready` tied 1:
  - SETUP then ACCESS with `psel=4'b0010`, `pstrb=4'hF`;
  - `rsp_valid` 3 cycles after accept, `rsp_err=0`.
- LB from 0x8000_0003 with slave 0 `prdata=0x80FF_FFFF`: `pstrb=0`, `rsp_rdata=0xFFFF_FF80`. LBU of the same access gives 0x0000_0080.
- SH to 0x8002_0002, data 0x1234, `pready` low for 2 cycles:
  - `pwdata=0x1234_1234`, `pstrb=4'b1100`;
  - signals stable across waits, `rsp_valid` at accept+5.
- LH from 0x8000_0001: no `psel`; `rsp_valid`, `rsp_err=1` at accept+2.
- LW with `pslverr=1` on completion: `rsp_err=1`, `rsp_rdata=0`. A back-to-back request accepted in the `rsp_valid` cycle completes normally.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYC=8`, `pready` held 0: abort after 8 ACCESS cycles with `rsp_err=1`. Reset pulsed mid-ACCESS clears `psel`/`penable` with no `rsp_valid`.
